ember_fetch_reader: RTL and testbench

Byte-serial instruction fetch reader for the Ember core. It reads the byte-wide L3 memory (`l3.mem`) and assembles 32-bit little-endian instruction words: byte at address A is bits [7:0], byte at A+3 is bits [31:24]. Assembled words go into a small buffer and are handed to the core front end over a valid/ready handshake. This block is the consumer of memory images written by the program loader and bench, and it replaces direct word peeks into `l3.mem`.

---
 rtl/ember_fetch_pkg.sv | 28 ++
 rtl/ember_fetch_fifo.sv | 56 +++++
 rtl/ember_fetch_reader.sv | 152 +++++++++++++++
 tb/tb_ember_fetch_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ember_fetch_pkg.sv
// Purpose : shared types and constants for the Ember instruction fetch path.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: fetch FSM state enum, bytes per instruction, and instruction
// field positions for the downstream decoder. The fetch reader does not decode.
package ember_fetch_pkg;

  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  // Instruction field positions, msb/lsb pairs.
  localparam int IMM_HI  = 31;
  localparam int IMM_LO  = 20;
  localparam int MODE_HI = 19;
  localparam int MODE_LO = 16;
  localparam int RS_HI   = 15;
  localparam int RS_LO   = 10;
  localparam int RD_HI   = 9;
  localparam int RD_LO   = 4;
  localparam int OP_HI   = 3;
  localparam int OP_LO   = 0;

endpackage

// File: rtl/ember_fetch_fifo.sv
// Purpose : synchronous FIFO of W-bit entries with push, pop, flush and occupancy count.
// Latency : a push is visible at the head on the cycle after it is written.
// Backpressure: none internally; the caller must not push when full or pop when empty.
// Ports: clk/rst (sync, active-high); push_vld/push_dat write the tail;
// pop_vld advances the head; flush empties the FIFO; head_dat is the oldest
// entry; count is the number of valid entries.
module ember_fetch_fifo
  import ember_fetch_pkg::*;
#(
  parameter int W     = 48,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  input  logic          flush,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as is; only the pointers and count are cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_vld) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push_vld) - CW'(pop_vld);
    end
  end

endmodule

// File: rtl/ember_fetch_reader.sv
// Purpose : byte-serial fetch from L3, assembling little-endian 32-bit instruction words.
// Latency : 5 cycles from the first byte read to the word being pushed; valid the cycle after.
// Backpressure: stops issuing reads at a word boundary when buffered + in-flight words fill the FIFO.
// Ports: clk/rst (sync, active-high); mem_rd_en/mem_addr issue one byte read
// per cycle and mem_rd_data returns it one cycle later; inst_valid/inst_ready
// hand over inst_data/inst_pc; redirect_valid/redirect_pc flush and restart.
module ember_fetch_reader
  import ember_fetch_pkg::*;
#(
  parameter int               ADDR_W     = 16,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int EW = ADDR_W + 32;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [1:0]        byte_idx;
  logic [1:0]        asm_cnt;
  logic              ret_vld;
  logic [1:0]        ret_idx;
  logic [ADDR_W-1:0] ret_pc;
  logic [23:0]       shift_dat;

  logic              issue;
  logic [ADDR_W-1:0] issue_pc;
  logic [1:0]        issue_idx;
  logic              word_start;
  logic              push_vld;
  logic              pop_vld;
  logic [EW-1:0]     push_dat;
  logic [EW-1:0]     head_dat;
  logic [CW-1:0]     fifo_cnt;
  logic [OW-1:0]     occ;
  logic              room;

  assign inst_valid = (fifo_cnt != '0);
  assign pop_vld    = inst_valid && inst_ready;
  assign inst_pc    = head_dat[EW-1:32];
  assign inst_data  = head_dat[31:0];

  // A redirect restarts at the aligned target, so the issue point is chosen
  // combinationally and the read goes out on the very next cycle.
  assign issue_pc   = redirect_valid ? (redirect_pc & ~ADDR_W'(3)) : fetch_pc;
  assign issue_idx  = redirect_valid ? 2'd0 : byte_idx;
  assign word_start = (issue_idx == 2'd0);

  // Slots claimed = words buffered + words whose byte 0 has been issued but
  // not yet pushed. A pop this cycle already frees its slot.
  assign occ  = OW'(fifo_cnt) + OW'(asm_cnt) - OW'(pop_vld);
  assign room = occ < OW'(FIFO_DEPTH);

  // A byte that returns while a redirect is applied belongs to the old stream.
  assign push_vld = ret_vld && (ret_idx == 2'd3) && !redirect_valid;
  assign push_dat = {ret_pc, mem_rd_data, shift_dat};

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = RUN;
        issue     = 1'b1;
      end
      RUN: begin
        if (word_start && !room) begin
          state_nxt = STALL;
        end else begin
          issue = 1'b1;
        end
      end
      STALL: begin
        if (room) begin
          state_nxt = RUN;
          issue     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      state_nxt = RUN;
      issue     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= RESET_PC;
      fetch_pc  <= RESET_PC;
      byte_idx  <= 2'd0;
      asm_cnt   <= 2'd0;
      ret_vld   <= 1'b0;
      ret_idx   <= 2'd0;
      ret_pc    <= '0;
      shift_dat <= '0;
    end else begin
      state     <= state_nxt;
      mem_rd_en <= issue;
      // fetch_pc tracks the word being issued, so it steps past a word as
      // soon as its last byte goes out; the returning word carries its own PC.
      if (issue) begin
        mem_addr <= issue_pc + ADDR_W'(issue_idx);
        byte_idx <= issue_idx + 2'd1;
        fetch_pc <= (issue_idx == 2'd3) ? issue_pc + ADDR_W'(INST_BYTES) : issue_pc;
      end
      asm_cnt <= (redirect_valid ? 2'd0 : asm_cnt - 2'(push_vld)) + 2'(issue && word_start);
      ret_vld <= mem_rd_en && !redirect_valid;
      ret_idx <= mem_addr[1:0];
      ret_pc  <= mem_addr & ~ADDR_W'(3);
      if (ret_vld && !redirect_valid) begin
        case (ret_idx)
          2'd0:    shift_dat[7:0]   <= mem_rd_data;
          2'd1:    shift_dat[15:8]  <= mem_rd_data;
          2'd2:    shift_dat[23:16] <= mem_rd_data;
          default: ;
        endcase
      end
    end
  end

  ember_fetch_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .flush    (redirect_valid),
    .head_dat (head_dat),
    .count    (fifo_cnt)
  );

endmodule

// File: tb/tb_ember_fetch_reader.sv
// Purpose : directed bench for ember_fetch_reader with a byte-wide L3 model.
// Latency : n/a.
// Backpressure: inst_ready is driven per scenario.
module tb_ember_fetch_reader;

  logic        clk;
  logic        rst;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [7:0]  l3_mem [65536];

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W0   = 32'h11522011;
  localparam logic [31:0] W1   = 32'h00110421;
  localparam logic [31:0] WTOP = 32'h12345678;

  ember_fetch_reader dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L3 returns the addressed byte one cycle after the request.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= l3_mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    ticks(2);
  endtask

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    mem_rd_data    = 8'h00;
    for (int i = 0; i < 65536; i++) l3_mem[i] = 8'h00;
    l3_mem[0] = 8'h11; l3_mem[1] = 8'h20; l3_mem[2] = 8'h52; l3_mem[3] = 8'h11;
    l3_mem[4] = 8'h21; l3_mem[5] = 8'h04; l3_mem[6] = 8'h11; l3_mem[7] = 8'h00;
    l3_mem[16'hFFFC] = 8'h78; l3_mem[16'hFFFD] = 8'h56;
    l3_mem[16'hFFFE] = 8'h34; l3_mem[16'hFFFF] = 8'h12;
    ticks(3);

    // Reset values.
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data",  inst_data,      32'd0);
    check("rst_pc",    32'(inst_pc),   32'd0);

    // Basic fetch, consumer always ready. Tick n observes cycle n.
    inst_ready = 1'b1;
    rst        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_rd_en", 32'(mem_rd_en), 32'd1);
      check("t1_addr",  32'(mem_addr),  32'(i));
    end
    tick();
    check("t1_valid_c5", 32'(inst_valid), 32'd0);
    tick();
    check("t1_valid_c6", 32'(inst_valid), 32'd1);
    check("t1_data_c6",  inst_data,       W0);
    check("t1_pc_c6",    32'(inst_pc),    32'd0);
    ticks(3);
    check("t1_valid_c9", 32'(inst_valid), 32'd0);
    tick();
    check("t1_valid_c10", 32'(inst_valid), 32'd1);
    check("t1_data_c10",  inst_data,       W1);
    check("t1_pc_c10",    32'(inst_pc),    32'd4);
    ticks(4);
    check("t1_valid_c14", 32'(inst_valid), 32'd1);
    check("t1_pc_c14",    32'(inst_pc),    32'd8);

    // Consumer stalled: two words buffer, then reads stop.
    do_reset();
    rst = 1'b0;
    ticks(6);
    check("t2_valid_c6", 32'(inst_valid), 32'd1);
    check("t2_data_c6",  inst_data,       W0);
    ticks(2);
    check("t2_rd_en_c8", 32'(mem_rd_en), 32'd1);
    check("t2_addr_c8",  32'(mem_addr),  32'd7);
    for (int i = 9; i <= 20; i++) begin
      tick();
      check("t2_stall_rd_en", 32'(mem_rd_en), 32'd0);
      check("t2_hold_data",   inst_data,      W0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t2_resume_rd_en", 32'(mem_rd_en), 32'd1);
    check("t2_resume_addr",  32'(mem_addr),  32'd8);
    check("t2_next_data",    inst_data,      W1);
    check("t2_next_pc",      32'(inst_pc),   32'd4);

    // Redirect to 0x0006 while byte 2 of word 0 is returning.
    do_reset();
    rst = 1'b0;
    ticks(4);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0006;
    for (int i = 0; i < 4; i++) begin
      tick();
      redirect_valid = 1'b0;
      check("t3_rd_en", 32'(mem_rd_en), 32'd1);
      check("t3_addr",  32'(mem_addr),  32'(4 + i));
    end
    tick();
    check("t3_valid_c9", 32'(inst_valid), 32'd0);
    tick();
    check("t3_valid_c10", 32'(inst_valid), 32'd1);
    check("t3_data_c10",  inst_data,       W1);
    check("t3_pc_c10",    32'(inst_pc),    32'd4);

    // Address wrap from 0xFFFC.
    do_reset();
    inst_ready = 1'b1;
    rst        = 1'b0;
    ticks(2);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFC;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] ea;
      ea = 16'hFFFC + 16'(i);
      tick();
      redirect_valid = 1'b0;
      check("t4_rd_en", 32'(mem_rd_en), 32'd1);
      check("t4_addr",  32'(mem_addr),  32'(ea));
    end
    tick();
    check("t4_valid_top", 32'(inst_valid), 32'd1);
    check("t4_data_top",  inst_data,       WTOP);
    check("t4_pc_top",    32'(inst_pc),    32'h0000FFFC);
    ticks(4);
    check("t4_valid_wrap", 32'(inst_valid), 32'd1);
    check("t4_data_wrap",  inst_data,       W0);
    check("t4_pc_wrap",    32'(inst_pc),    32'd0);

    // Reset in the middle of assembling word 1.
    do_reset();
    rst = 1'b0;
    ticks(8);
    check("t5_pre_data", inst_data, W0);
    rst = 1'b1;
    tick();
    check("t5_rd_en",  32'(mem_rd_en),  32'd0);
    check("t5_addr",   32'(mem_addr),   32'd0);
    check("t5_valid",  32'(inst_valid), 32'd0);
    check("t5_data",   inst_data,       32'd0);
    check("t5_pc",     32'(inst_pc),    32'd0);
    tick();
    rst = 1'b0;
    ticks(5);
    check("t5_valid_c5", 32'(inst_valid), 32'd0);
    tick();
    check("t5_valid_c6", 32'(inst_valid), 32'd1);
    check("t5_data_c6",  inst_data,       W0);
    check("t5_pc_c6",    32'(inst_pc),    32'd0);

    // Redirect and pop together with a full FIFO.
    do_reset();
    rst = 1'b0;
    ticks(10);
    check("t6_full_valid", 32'(inst_valid), 32'd1);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    check("t6_flush_valid", 32'(inst_valid), 32'd0);
    for (int i = 12; i <= 15; i++) begin
      tick();
      check("t6_no_stale", 32'(inst_valid), 32'd0);
    end
    tick();
    check("t6_valid_r6", 32'(inst_valid), 32'd1);
    check("t6_data_r6",  inst_data,       W0);
    check("t6_pc_r6",    32'(inst_pc),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
